// File: rtl/pi_loop_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pi_loop_filter_pkg
// Description : Shared definitions for the ADPLL PI loop filter: FSM state
//               encodings, default control-word geometry and the phase-error
//               sign convention used by the phase detector and the DCO.
// Revision    : 1.0  initial release
// ============================================================================
package pi_loop_filter_pkg;

    // Default DCO control-word geometry. CENTRE is the free-running code.
    localparam int DEFAULT_CTRL_WIDTH = 10;
    localparam int DEFAULT_CENTRE     = 512;

    // Phase-error sign convention: a positive error (DCO lagging the
    // reference) must raise the DCO control word.
    localparam int PE_SIGN_POSITIVE_RAISES_CTRL = 1;

    // Filter sequencer encodings, one cycle per state.
    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_INTEG = 2'd1;
    localparam logic [1:0] C_ST_SUM   = 2'd2;
    localparam logic [1:0] C_ST_OUT   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = C_ST_IDLE,
        ST_INTEG = C_ST_INTEG,
        ST_SUM   = C_ST_SUM,
        ST_OUT   = C_ST_OUT
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pi_loop_filter_if.sv
`default_nettype none
// ============================================================================
// Module      : pi_loop_filter_if
// Description : Phase-detector / DCO side signals of the PI loop filter.
//               master : phase detector side (drives error, strobe, hold)
//               slave  : loop filter (drives DCO word and status flags)
//   pd_clock_cycles_i  signed phase error in fpga_clk cycles
//   pd_valid_i         one-cycle strobe for a new measurement
//   hold_i             freeze the integrator
//   dco_ctrl_o         registered DCO control word
//   dco_ctrl_valid_o   one-cycle pulse on control-word update
//   locked_o           loop in lock
//   saturated_o        last control word was clamped
//   overrun_o          measurement dropped while busy
// Revision    : 1.0  initial release
// ============================================================================
interface pi_loop_filter_if
    import pi_loop_filter_pkg::*;
#(
    parameter int PD_WIDTH   = 8,
    parameter int CTRL_WIDTH = DEFAULT_CTRL_WIDTH
);
    logic signed [PD_WIDTH-1:0] pd_clock_cycles_i;
    logic                       pd_valid_i;
    logic                       hold_i;
    logic [CTRL_WIDTH-1:0]      dco_ctrl_o;
    logic                       dco_ctrl_valid_o;
    logic                       locked_o;
    logic                       saturated_o;
    logic                       overrun_o;

    modport master (
        output pd_clock_cycles_i, pd_valid_i, hold_i,
        input  dco_ctrl_o, dco_ctrl_valid_o, locked_o, saturated_o, overrun_o
    );

    modport slave (
        input  pd_clock_cycles_i, pd_valid_i, hold_i,
        output dco_ctrl_o, dco_ctrl_valid_o, locked_o, saturated_o, overrun_o
    );
endinterface
`default_nettype wire

// File: rtl/pi_loop_filter_lock_detector.sv
`default_nettype none
// ============================================================================
// Module      : pi_loop_filter_lock_detector
// Description : Counts consecutive small phase errors; lock is declared once
//               LOCK_COUNT in-tolerance samples have been seen in a row.
//   clk, rst   clock / async active-high reset
//   i_e        signed phase error
//   i_strobe   evaluate i_e this cycle
//   o_locked   counter has reached LOCK_COUNT
// Revision    : 1.0  initial release
// ============================================================================
module pi_loop_filter_lock_detector #(
    parameter int PD_WIDTH   = 8,
    parameter int LOCK_TOL   = 1,
    parameter int LOCK_COUNT = 16
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic signed [PD_WIDTH-1:0] i_e,
    input  wire logic                       i_strobe,
    output logic                            o_locked
);
    localparam int                  c_cnt_w   = $clog2(LOCK_COUNT + 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_max = c_cnt_w'(LOCK_COUNT);
    localparam logic [PD_WIDTH:0]   c_tol     = (PD_WIDTH+1)'(LOCK_TOL);

    // One extra bit so the magnitude of the most negative input is exact.
    logic signed [PD_WIDTH:0] w_e_ext;
    logic        [PD_WIDTH:0] w_mag;
    logic                     w_in_tol;
    logic [c_cnt_w-1:0]       r_count;

    assign w_e_ext  = {i_e[PD_WIDTH-1], i_e};
    assign w_mag    = w_e_ext[PD_WIDTH] ? $unsigned(-w_e_ext) : $unsigned(w_e_ext);
    assign w_in_tol = (w_mag <= c_tol);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_strobe) begin
            if (!w_in_tol) begin
                r_count <= '0;
            end else if (r_count != c_cnt_max) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_locked = (r_count == c_cnt_max);

endmodule
`default_nettype wire

// File: rtl/pi_loop_filter.sv
`default_nettype none
// ============================================================================
// Module      : pi_loop_filter
// Description : ADPLL PI loop filter. Each phase-error strobe runs through
//               IDLE -> INTEG -> SUM -> OUT; the clamped control word and a
//               valid pulse appear in the OUT cycle (3 cycles after strobe).
//   fpga_clk_i  system clock
//   reset_i     async active-high reset
//   bus         pi_loop_filter_if.slave (error in, DCO word and flags out)
// Revision    : 1.0  initial release
// ============================================================================
module pi_loop_filter
    import pi_loop_filter_pkg::*;
#(
    parameter int PD_WIDTH   = 8,
    parameter int CTRL_WIDTH = DEFAULT_CTRL_WIDTH,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int KP_SHIFT   = 2,
    parameter int KI_SHIFT   = 5,
    parameter int CENTRE     = DEFAULT_CENTRE,
    parameter int LOCK_TOL   = 1,
    parameter int LOCK_COUNT = 16
) (
    input  wire logic           fpga_clk_i,
    input  wire logic           reset_i,
    pi_loop_filter_if.slave     bus
);
    localparam logic signed [ACC_WIDTH-1:0] c_centre_fx =
        ACC_WIDTH'(CENTRE) <<< FRAC_BITS;
    // Integrator limits: the integrator alone can drive the output exactly
    // to either end of the control range, never beyond (anti-windup).
    localparam logic signed [ACC_WIDTH-1:0] c_i_max =
        ACC_WIDTH'((2**CTRL_WIDTH) - 1 - CENTRE) <<< FRAC_BITS;
    localparam logic signed [ACC_WIDTH-1:0] c_i_min = -c_centre_fx;
    localparam logic signed [ACC_WIDTH-1:0] c_q_max =
        ACC_WIDTH'((2**CTRL_WIDTH) - 1);
    localparam logic [CTRL_WIDTH-1:0] c_ctrl_max    = '1;
    localparam logic [CTRL_WIDTH-1:0] c_ctrl_centre = CTRL_WIDTH'(CENTRE);

    state_t                         r_state;
    logic signed [PD_WIDTH-1:0]     r_e;
    logic signed [ACC_WIDTH-1:0]    r_p;
    logic signed [ACC_WIDTH-1:0]    r_i_acc;
    logic [CTRL_WIDTH-1:0]          r_dco_ctrl;
    logic                           r_dco_valid;
    logic                           r_saturated;

    logic signed [ACC_WIDTH-1:0]    w_e_ext;
    logic signed [ACC_WIDTH-1:0]    w_p_term;
    logic signed [ACC_WIDTH-1:0]    w_i_term;
    logic signed [ACC_WIDTH-1:0]    w_i_sum;
    logic signed [ACC_WIDTH-1:0]    w_i_clamped;
    logic signed [ACC_WIDTH-1:0]    w_sum;
    logic signed [ACC_WIDTH-1:0]    w_q;
    logic [CTRL_WIDTH-1:0]          w_ctrl_next;
    logic                           w_sat_next;
    logic                           w_lock_strobe;
    logic                           w_locked;

    // ---------------------------------------------------------------- datapath
    assign w_e_ext  = {{(ACC_WIDTH-PD_WIDTH){r_e[PD_WIDTH-1]}}, r_e};
    assign w_p_term = w_e_ext <<< (FRAC_BITS - KP_SHIFT);
    assign w_i_term = w_e_ext <<< (FRAC_BITS - KI_SHIFT);
    assign w_i_sum  = r_i_acc + w_i_term;

    always_comb begin
        w_i_clamped = w_i_sum;
        if (w_i_sum > c_i_max) begin
            w_i_clamped = c_i_max;
        end else if (w_i_sum < c_i_min) begin
            w_i_clamped = c_i_min;
        end
    end

    // Formed during SUM from the integrator value written in INTEG.
    assign w_sum = c_centre_fx + r_p + r_i_acc;
    assign w_q   = w_sum >>> FRAC_BITS;

    always_comb begin
        w_ctrl_next = w_q[CTRL_WIDTH-1:0];
        w_sat_next  = 1'b0;
        if (w_q < 0) begin
            w_ctrl_next = '0;
            w_sat_next  = 1'b1;
        end else if (w_q > c_q_max) begin
            w_ctrl_next = c_ctrl_max;
            w_sat_next  = 1'b1;
        end
    end

    // ------------------------------------------------------------- sequencer
    // The output registers are loaded at the end of SUM so that the new word
    // and its valid pulse are visible throughout the OUT cycle.
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= ST_IDLE;
            r_e         <= '0;
            r_p         <= '0;
            r_i_acc     <= '0;
            r_dco_ctrl  <= c_ctrl_centre;
            r_dco_valid <= 1'b0;
            r_saturated <= 1'b0;
        end else begin
            r_dco_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.pd_valid_i) begin
                        r_e     <= bus.pd_clock_cycles_i;
                        r_state <= ST_INTEG;
                    end
                end
                ST_INTEG: begin
                    r_p <= w_p_term;
                    if (!bus.hold_i) begin
                        r_i_acc <= w_i_clamped;
                    end
                    r_state <= ST_SUM;
                end
                ST_SUM: begin
                    r_dco_ctrl  <= w_ctrl_next;
                    r_saturated <= w_sat_next;
                    r_dco_valid <= 1'b1;
                    r_state     <= ST_OUT;
                end
                ST_OUT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------- lock
    assign w_lock_strobe = (r_state == ST_INTEG);

    pi_loop_filter_lock_detector #(
        .PD_WIDTH   (PD_WIDTH),
        .LOCK_TOL   (LOCK_TOL),
        .LOCK_COUNT (LOCK_COUNT)
    ) u_lock_detector (
        .clk      (fpga_clk_i),
        .rst      (reset_i),
        .i_e      (r_e),
        .i_strobe (w_lock_strobe),
        .o_locked (w_locked)
    );

    // ------------------------------------------------------------- outputs
    assign bus.dco_ctrl_o       = r_dco_ctrl;
    assign bus.dco_ctrl_valid_o = r_dco_valid;
    assign bus.saturated_o      = r_saturated;
    assign bus.locked_o         = w_locked;
    // Dropped-sample flag must coincide with the offending strobe.
    assign bus.overrun_o        = bus.pd_valid_i && (r_state != ST_IDLE);

endmodule
`default_nettype wire
